// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - GPIO pad synchroniser, per-bit debouncer and edge detector.
// Optional edge-latched pending/irq logic is built when GPIO_IN_FILTER_EDGE_IRQ_EN is defined.
module gpio_in_filter #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pad_i,
    input  logic             bypass,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pending,
    input  logic [WIDTH-1:0] irq_clr,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] o_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RST_VAL;
        end else begin
            sync_q[0] <= pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A bit is accepted only after it has differed from o for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        o_next = o;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_next[b] = '0;
            if (bypass) begin
                o_next[b] = s[b];
            end else if (s[b] != o[b]) begin
                if (cnt[b] == CNT_MAX) o_next[b] = s[b];
                else                   cnt_next[b] = cnt[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o    <= RST_VAL;
            rise <= '0;
            fall <= '0;
            for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
        end else begin
            o    <= o_next;
            rise <= o_next & ~o;
            fall <= ~o_next & o;
            for (int b = 0; b < WIDTH; b++) cnt[b] <= cnt_next[b];
        end
    end

`ifdef GPIO_IN_FILTER_EDGE_IRQ_EN
    // Set terms come from the same next-state edges that load rise/fall, so set beats clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending <= '0;
        else       pending <= (pending & ~irq_clr) | (o_next ^ o);
    end

    assign irq = |pending;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = ^irq_clr;
    assign pending        = '0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb/tb_gpio_in_filter.sv - randomized bench for gpio_in_filter against a sliding-window model.
module tb_gpio_in_filter;
    localparam int W   = 4;
    localparam int SYN = 2;
    localparam int DEB = 4;
`ifdef GPIO_IN_FILTER_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [W-1:0] pad = '0;
    logic         bypass = 1'b0;
    logic [W-1:0] irq_clr = '0;
    logic [W-1:0] o, rise, fall, pending;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    gpio_in_filter #(
        .WIDTH(W), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .RST_VAL(4'h0)
    ) dut (
        .clk(clk), .rstn(rstn), .pad_i(pad), .bypass(bypass), .o(o), .rise(rise),
        .fall(fall), .pending(pending), .irq_clr(irq_clr), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: o flips only when the last DEB synchronised samples all differ from it,
    // none of them taken under bypass and all taken since reset release.
    logic [W-1:0] padq[$];
    logic [W-1:0] hs [DEB];
    bit           hb [DEB];
    int           nhist;
    logic [W-1:0] m_o, m_rise, m_fall, m_pend, sv, new_o;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_o = '0; m_rise = '0; m_fall = '0; m_pend = '0; nhist = 0;
            padq.delete();
            for (int i = 0; i < SYN; i++) padq.push_back('0);
        end else begin
            sv = padq[$];
            padq.pop_back();
            padq.push_front(pad);
            for (int j = DEB - 1; j > 0; j--) begin hs[j] = hs[j-1]; hb[j] = hb[j-1]; end
            hs[0] = sv; hb[0] = bypass;
            if (nhist < DEB) nhist++;
            for (int b = 0; b < W; b++) begin
                if (bypass) new_o[b] = sv[b];
                else begin
                    bit ok;
                    ok = (nhist >= DEB);
                    for (int j = 0; j < DEB; j++) ok &= (hs[j][b] != m_o[b]) && !hb[j];
                    new_o[b] = ok ? ~m_o[b] : m_o[b];
                end
            end
            m_rise = new_o & ~m_o;
            m_fall = ~new_o & m_o;
            if (IRQ_EN) m_pend = (m_pend & ~irq_clr) | m_rise | m_fall;
            m_o = new_o;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("o", 32'(o), 32'(m_o));
            check("rise", 32'(rise), 32'(m_rise));
            check("fall", 32'(fall), 32'(m_fall));
            check("pending", 32'(pending), 32'(m_pend));
            check("irq", 32'(irq), 32'(|m_pend));
            check("rise_and_fall", 32'(rise & fall), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hold [W];

    initial begin
        // Scenario 1: reset with all pads high
        pad = 4'hF;
        #2 rstn = 1'b0;
        chk_en = 1'b1;
        tick(4);
        check("rst_o", 32'(o), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        pad = 4'h0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // Scenario 2: clean rising edge on bit 0
        pad[0] = 1'b1;
        tick(5);
        check("s2_o_before", 32'(o[0]), 32'h0);
        tick(1);
        check("s2_o_after", 32'(o[0]), 32'h1);
        check("s2_rise", 32'(rise), 32'h1);
        tick(1);
        check("s2_rise_gone", 32'(rise), 32'h0);
        check("s2_pending", 32'(pending), IRQ_EN ? 32'h1 : 32'h0);
        check("s2_irq", 32'(irq), 32'(IRQ_EN));

        // Scenario 3: glitch shorter than the debounce window
        pad[1] = 1'b1;
        tick(3);
        pad[1] = 1'b0;
        tick(10);
        check("s3_o1", 32'(o[1]), 32'h0);
        check("s3_pend1", 32'(pending[1]), 32'h0);

        // Scenario 4: clear coincident with a new fall, then clear alone
        pad[0] = 1'b0;
        tick(5);
        irq_clr = 4'h1;
        tick(1);
        check("s4_fall", 32'(fall), 32'h1);
        check("s4_pend_set_wins", 32'(pending[0]), 32'(IRQ_EN));
        tick(1);
        check("s4_pend_clr", 32'(pending), 32'h0);
        check("s4_irq_clr", 32'(irq), 32'h0);
        irq_clr = 4'h0;

        // Scenario 5: bypass passes a one-cycle pulse
        bypass = 1'b1;
        pad[2] = 1'b1;
        tick(1);
        pad[2] = 1'b0;
        tick(2);
        check("s5_o2_hi", 32'(o[2]), 32'h1);
        check("s5_rise2", 32'(rise), 32'h4);
        tick(1);
        check("s5_o2_lo", 32'(o[2]), 32'h0);
        check("s5_fall2", 32'(fall), 32'h4);
        bypass = 1'b0;
        tick(2);

        // Scenario 6: reset mid-count
        pad[3] = 1'b1;
        tick(4);
        rstn = 1'b0;
        #1 check("s6_o_in_reset", 32'(o), 32'h0);
        #1 rstn = 1'b1;
        tick(5);
        check("s6_o3_before", 32'(o[3]), 32'h0);
        tick(1);
        check("s6_o3_after", 32'(o[3]), 32'h1);
        pad[3] = 1'b0;
        tick(8);

        // Randomized phase
        for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++) begin
                if (hold[b] == 0) begin
                    pad[b] = ~pad[b];
                    hold[b] = $urandom_range(1, 12);
                end else hold[b]--;
            end
            if ($urandom_range(0, 199) == 0) bypass = ~bypass;
            irq_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                tick($urandom_range(1, 2));
                rstn = 1'b1;
            end
            tick(1);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
